// File: rtl/multicycle_sequencer.sv
//------------------------------------------------------------------------------
// multicycle_sequencer
//
// Sequences the multi-cycle RV32I datapath through
// FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITE and drives one enable per
// stage. Around that sequence it provides:
//   - req/ack handshakes with instruction and data memory,
//   - run/halt control,
//   - an internal PC register with an alignment check on the next PC,
//   - a memory-wait timeout,
//   - a retired-instruction counter.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   run                 1 = keep executing, 0 = stop after current instruction
//   imem_req/imem_ack   instruction memory handshake (req high in FETCH)
//   dmem_req/dmem_ack   data memory handshake (req high in MEMORY)
//   need_mem, need_wb   decoder flags, sampled in DECODE
//   halt_req            decoder ebreak/illegal flag, sampled in DECODE
//   pc_next             next PC from the PC mux, consumed in WRITE
//   pc                  current PC
//   if_en..wb_en        per-stage enables (Moore, from the registered state)
//   retire              pulse in WRITE when the instruction completes
//   halted, err         sticky halt / error flags
//   instret             retired-instruction count (wraps)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module multicycle_sequencer #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = {XLEN{1'b0}},
    parameter int              MEM_TIMEOUT = 16,
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    input  logic             dmem_ack,
    input  logic             need_mem,
    input  logic             need_wb,
    input  logic             halt_req,
    input  logic [XLEN-1:0]  pc_next,
    output logic [XLEN-1:0]  pc,
    output logic             if_en,
    output logic             id_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             retire,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        ST_HALT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_FETCH   = 3'd2,
        ST_DECODE  = 3'd3,
        ST_EXECUTE = 3'd4,
        ST_MEMORY  = 3'd5,
        ST_WRITE   = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

    // The wait counter only has to reach MEM_TIMEOUT-1: at that count an
    // ack-less cycle leaves the wait state for ERROR.
    localparam int              WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
    localparam logic            TIMEOUT_ON = (MEM_TIMEOUT > 0);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [XLEN-1:0]   pc_r;
    logic [CNT_W-1:0]  instret_r;
    logic              halted_r;
    logic              err_r;
    logic              need_mem_r;
    logic              need_wb_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              wait_last_s;
    logic              misalign_s;
    logic              commit_s;

    // Next-state logic and the WRITE-stage commit decision.
    always_comb begin
        state_nxt_s = state_r;
        wait_last_s = TIMEOUT_ON && (wait_cnt_r == WAIT_LAST);
        misalign_s  = (pc_next[1:0] != 2'b00);
        commit_s    = 1'b0;
        case (state_r)
            ST_HALT: begin
                state_nxt_s = ST_IDLE;
            end
            ST_IDLE: begin
                if (run && !halted_r) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // An ack in the last allowed wait cycle still wins.
                if (imem_ack) begin
                    state_nxt_s = ST_DECODE;
                end else if (wait_last_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (halt_req) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (need_mem_r) begin
                    state_nxt_s = ST_MEMORY;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_MEMORY: begin
                if (dmem_ack) begin
                    state_nxt_s = ST_WRITE;
                end else if (wait_last_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_MEMORY;
                end
            end
            ST_WRITE: begin
                // A misaligned next PC aborts the instruction without retiring it.
                if (misalign_s) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    commit_s = 1'b1;
                    if (run) begin
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
            end
            ST_ERROR: begin
                state_nxt_s = ST_ERROR;
            end
            default: begin
                state_nxt_s = ST_ERROR;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_HALT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // PC and retired-instruction counter, updated only on a clean commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r      <= RESET_PC;
            instret_r <= {CNT_W{1'b0}};
        end else if (commit_s) begin
            pc_r      <= pc_next;
            instret_r <= instret_r + CNT_W'(1'b1);
        end else begin
            pc_r      <= pc_r;
            instret_r <= instret_r;
        end
    end

    // Sticky halt and error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            if (state_r == ST_DECODE && halt_req) begin
                halted_r <= 1'b1;
            end else if (state_r == ST_IDLE && !run) begin
                halted_r <= 1'b0;
            end else begin
                halted_r <= halted_r;
            end
            err_r <= err_r | (state_nxt_s == ST_ERROR);
        end
    end

    // Decoder flags captured in DECODE for use in later stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            need_mem_r <= 1'b0;
            need_wb_r  <= 1'b0;
        end else if (state_r == ST_DECODE) begin
            need_mem_r <= need_mem;
            need_wb_r  <= need_wb;
        end else begin
            need_mem_r <= need_mem_r;
            need_wb_r  <= need_wb_r;
        end
    end

    // Wait counter: zero outside FETCH/MEMORY, so it restarts on every entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (TIMEOUT_ON && state_nxt_s == state_r &&
                     (state_r == ST_FETCH || state_r == ST_MEMORY)) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1'b1);
        end else begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end
    end

    assign if_en    = (state_r == ST_FETCH);
    assign id_en    = (state_r == ST_DECODE);
    assign exe_en   = (state_r == ST_EXECUTE);
    assign mem_en   = (state_r == ST_MEMORY);
    assign wb_en    = (state_r == ST_WRITE) && need_wb_r;
    assign imem_req = (state_r == ST_FETCH);
    assign dmem_req = (state_r == ST_MEMORY);
    assign retire   = commit_s;
    assign pc       = pc_r;
    assign instret  = instret_r;
    assign halted   = halted_r;
    assign err      = err_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
//------------------------------------------------------------------------------
// Directed self-checking bench for multicycle_sequencer.
// Instance uses RESET_PC=0x100, MEM_TIMEOUT=4 and CNT_W=4 so that timeout and
// counter wrap are reachable in a short run.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_multicycle_sequencer;

    localparam logic [31:0] RPC = 32'h0000_0100;

    // Enable vector order: {if, id, exe, mem, wb, retire, imem_req, dmem_req}
    localparam logic [7:0] EN_NONE  = 8'b0000_0000;
    localparam logic [7:0] EN_FETCH = 8'b1000_0010;
    localparam logic [7:0] EN_DEC   = 8'b0100_0000;
    localparam logic [7:0] EN_EXE   = 8'b0010_0000;
    localparam logic [7:0] EN_MEM   = 8'b0001_0001;
    localparam logic [7:0] EN_WB    = 8'b0000_1100;
    localparam logic [7:0] EN_WRNW  = 8'b0000_0100;
    localparam logic [7:0] EN_WBAD  = 8'b0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        imem_req, imem_ack;
    logic        dmem_req, dmem_ack;
    logic        need_mem, need_wb, halt_req;
    logic [31:0] pc_next;
    logic [31:0] pc;
    logic        if_en, id_en, exe_en, mem_en, wb_en, retire, halted, err;
    logic [3:0]  instret;
    logic        bad_pc;
    logic [7:0]  en_v;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cyc_start;

    multicycle_sequencer #(
        .XLEN(32), .RESET_PC(RPC), .MEM_TIMEOUT(4), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .need_mem(need_mem), .need_wb(need_wb), .halt_req(halt_req),
        .pc_next(pc_next), .pc(pc),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en),
        .wb_en(wb_en), .retire(retire), .halted(halted), .err(err),
        .instret(instret)
    );

    always #5 clk = ~clk;

    // The PC mux normally supplies pc+4; bad_pc forces a misaligned target.
    assign pc_next = bad_pc ? 32'h0000_0006 : pc + 32'd4;
    assign en_v    = {if_en, id_en, exe_en, mem_en, wb_en, retire, imem_req, dmem_req};

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        need_mem = 1'b0; need_wb = 1'b1; halt_req = 1'b0; bad_pc = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_en", {24'd0, en_v}, {24'd0, EN_NONE});
        chk("rst_pc", pc, RPC);
        chk("rst_instret", {28'd0, instret}, 32'd0);
        chk("rst_flags", {30'd0, halted, err}, 32'd0);
        rst = 1'b0;
        tick();                                  // HALT -> IDLE
        chk("idle_en", {24'd0, en_v}, {24'd0, EN_NONE});

        // Three back-to-back instructions, zero-wait acks, no memory stage
        imem_ack = 1'b1; dmem_ack = 1'b1; run = 1'b1;
        tick();                                  // IDLE -> FETCH
        for (int i = 0; i < 3; i++) begin
            chk("seq_fetch", {24'd0, en_v}, {24'd0, EN_FETCH});
            chk("seq_pc", pc, RPC + 32'(4 * i));
            chk("seq_instret", {28'd0, instret}, 32'(i));
            tick(); chk("seq_dec", {24'd0, en_v}, {24'd0, EN_DEC});
            tick(); chk("seq_exe", {24'd0, en_v}, {24'd0, EN_EXE});
            tick(); chk("seq_wb", {24'd0, en_v}, {24'd0, EN_WB});
            tick();
        end
        chk("seq3_pc", pc, 32'h0000_010C);
        chk("seq3_instret", {28'd0, instret}, 32'd3);

        // Memory stage with dmem_ack arriving in the 4th MEMORY cycle
        need_mem = 1'b1; need_wb = 1'b0; dmem_ack = 1'b0;
        cyc_start = cyc;
        tick(); chk("mem_dec", {24'd0, en_v}, {24'd0, EN_DEC});
        tick(); chk("mem_exe", {24'd0, en_v}, {24'd0, EN_EXE});
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("mem_wait", {24'd0, en_v}, {24'd0, EN_MEM});
            if (k == 3) dmem_ack = 1'b1;
            tick();
        end
        chk("mem_write_nowb", {24'd0, en_v}, {24'd0, EN_WRNW});
        need_mem = 1'b0; need_wb = 1'b1;
        tick();
        chk("mem_latency", 32'(cyc - cyc_start), 32'd8);
        chk("mem_fetch", {24'd0, en_v}, {24'd0, EN_FETCH});
        chk("mem_pc", pc, 32'h0000_0110);
        chk("mem_instret", {28'd0, instret}, 32'd4);

        // halt_req in DECODE
        halt_req = 1'b1;
        tick(); chk("halt_dec", {24'd0, en_v}, {24'd0, EN_DEC});
        tick(); halt_req = 1'b0;
        chk("halt_idle", {24'd0, en_v}, {24'd0, EN_NONE});
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_instret", {28'd0, instret}, 32'd4);
        chk("halt_pc", pc, 32'h0000_0110);
        tick(); chk("halt_stays", {24'd0, en_v}, {24'd0, EN_NONE});
        run = 1'b0;
        tick(); chk("halt_clear", {31'd0, halted}, 32'd0);
        run = 1'b1;
        tick(); chk("refetch_en", {24'd0, en_v}, {24'd0, EN_FETCH});
        chk("refetch_pc", pc, 32'h0000_0110);
        tick(); tick(); tick();
        imem_ack = 1'b0;                         // next fetch waits
        tick();
        chk("refetch_done_pc", pc, 32'h0000_0114);

        // Fetch ack in the 4th (last allowed) wait cycle: no error
        for (int k = 0; k < 4; k++) begin
            chk("fack4_fetch", {24'd0, en_v}, {24'd0, EN_FETCH});
            if (k == 3) imem_ack = 1'b1;
            tick();
        end
        chk("fack4_dec", {24'd0, en_v}, {24'd0, EN_DEC});
        chk("fack4_noerr", {31'd0, err}, 32'd0);
        tick(); tick();
        imem_ack = 1'b0;
        tick();
        chk("fack4_pc", pc, 32'h0000_0118);
        chk("fack4_instret", {28'd0, instret}, 32'd6);

        // Fetch timeout: 4 FETCH cycles then ERROR
        for (int k = 0; k < 4; k++) begin
            chk("tmo_fetch", {24'd0, en_v}, {24'd0, EN_FETCH});
            tick();
        end
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_en", {24'd0, en_v}, {24'd0, EN_NONE});
        imem_ack = 1'b1; dmem_ack = 1'b1;
        tick(); tick();
        chk("tmo_sticky", {31'd0, err}, 32'd1);
        chk("tmo_en_frozen", {24'd0, en_v}, {24'd0, EN_NONE});
        chk("tmo_pc", pc, 32'h0000_0118);
        chk("tmo_instret", {28'd0, instret}, 32'd6);

        // Asynchronous reset out of ERROR
        rst = 1'b1; #1;
        chk("arst_err", {31'd0, err}, 32'd0);
        chk("arst_pc", pc, RPC);
        chk("arst_instret", {28'd0, instret}, 32'd0);
        tick(); rst = 1'b0;
        tick(); tick();                          // HALT -> IDLE -> FETCH
        chk("mis_fetch", {24'd0, en_v}, {24'd0, EN_FETCH});

        // Misaligned next PC in WRITE
        tick(); tick(); tick();
        bad_pc = 1'b1; #1;
        chk("mis_write", {24'd0, en_v}, {24'd0, EN_WBAD});
        tick(); bad_pc = 1'b0;
        chk("mis_err", {31'd0, err}, 32'd1);
        chk("mis_pc", pc, RPC);
        chk("mis_instret", {28'd0, instret}, 32'd0);

        // Counter wrap with CNT_W=4 over 16 instructions
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); tick();
        for (int i = 0; i < 16; i++) begin
            chk("wrap_instret", {28'd0, instret}, 32'(i % 16));
            chk("wrap_pc", pc, RPC + 32'(4 * i));
            tick(); tick(); tick(); tick();
        end
        chk("wrap_zero", {28'd0, instret}, 32'd0);
        chk("wrap_pc_end", pc, 32'h0000_0140);

        // Reset while waiting in MEMORY
        need_mem = 1'b1; dmem_ack = 1'b0;
        tick(); tick(); tick();
        chk("mrst_mem", {24'd0, en_v}, {24'd0, EN_MEM});
        tick();
        chk("mrst_mem2", {24'd0, en_v}, {24'd0, EN_MEM});
        rst = 1'b1; #1;
        chk("mrst_en", {24'd0, en_v}, {24'd0, EN_NONE});
        chk("mrst_pc", pc, RPC);
        chk("mrst_flags", {30'd0, halted, err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
